// File: rtl/div_unit.sv
// Iterative RV64M divide/remainder unit: radix-2 restoring division on operand
// magnitudes, one quotient bit per cycle, with valid/ready request and result handshakes.
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic [2:0]      div_op,
  input  logic [XLEN-1:0] div_src1,
  input  logic [XLEN-1:0] div_src2,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic            rem_op_q, word_q, q_sign_q, r_sign_q;

  // Request decode, evaluated only on the accept edge.
  logic            is_rem, is_uns, is_word;
  logic [XLEN-1:0] a1, a2, mag1, mag2, most_neg, src1_sx, special_res;
  logic            s1, s2, div_zero, ovf, accept;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_rem   = div_op[0];
    is_uns   = div_op[1];
    is_word  = div_op[2];
    src1_sx  = {{HALF{div_src1[HALF-1]}}, div_src1[HALF-1:0]};
    a1       = is_word ? {{HALF{div_src1[HALF-1] & ~is_uns}}, div_src1[HALF-1:0]} : div_src1;
    a2       = is_word ? {{HALF{div_src2[HALF-1] & ~is_uns}}, div_src2[HALF-1:0]} : div_src2;
    s1       = ~is_uns & a1[XLEN-1];
    s2       = ~is_uns & a2[XLEN-1];
    mag1     = s1 ? -a1 : a1;
    mag2     = s2 ? -a2 : a2;
    most_neg = is_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                       : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (a2 == '0);
    ovf      = ~is_uns & (a1 == most_neg) & (&a2);
    if (div_zero) special_res = is_rem ? (is_word ? src1_sx : div_src1) : '1;
    else          special_res = is_rem ? '0 : a1;
    accept   = div_valid & (state == IDLE) & ~flush;
  end

  // One restoring step: trial needs one extra bit since 2*rem+1 can exceed XLEN bits.
  logic [XLEN:0]   trial, diff;
  logic            ge;
  logic [XLEN-1:0] rem_n, quo_n, q_fix, r_fix, pick, final_res;

  always_comb begin
    trial     = {rem_q, quo_q[XLEN-1]};
    diff      = trial - {1'b0, dvsr_q};
    ge        = ~diff[XLEN];
    rem_n     = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
    quo_n     = {quo_q[XLEN-2:0], ge};
    q_fix     = q_sign_q ? -quo_n : quo_n;
    r_fix     = r_sign_q ? -rem_n : rem_n;
    pick      = rem_op_q ? r_fix : q_fix;
    final_res = word_q ? {{HALF{pick[HALF-1]}}, pick[HALF-1:0]} : pick;
  end

  assign div_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      count        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvsr_q       <= '0;
      rem_op_q     <= 1'b0;
      word_q       <= 1'b0;
      q_sign_q     <= 1'b0;
      r_sign_q     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      count        <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem_op_q <= is_rem;
            word_q   <= is_word;
            q_sign_q <= s1 ^ s2;
            r_sign_q <= s1;
            dvsr_q   <= mag2;
            rem_q    <= '0;
            // Word magnitudes sit in the upper half so the MSB shifts out first.
            quo_q    <= is_word ? {mag1[HALF-1:0], {HALF{1'b0}}} : mag1;
            if (div_zero || ovf) begin
              result <= special_res;
              count  <= '0;
              state  <= DONE;
            end else begin
              count  <= is_word ? CW'(HALF) : CW'(XLEN);
              state  <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            result       <= final_res;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          // Special cases arrive here with result_valid still low; raise it one edge later.
          if (!result_valid) begin
            result_valid <= 1'b1;
          end else if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed RV64M results, latency, hold, flush and reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic [2:0]  div_op = '0;
  logic [63:0] div_src1 = '0;
  logic [63:0] div_src2 = '0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] OP_DIV = 3'b000, OP_REM = 3'b001, OP_DIVU = 3'b010, OP_REMU = 3'b011,
                         OP_DIVW = 3'b100, OP_REMW = 3'b101, OP_DIVUW = 3'b110, OP_REMUW = 3'b111;

  div_unit #(.XLEN(64)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .div_valid(div_valid), .div_ready(div_ready), .div_op(div_op),
    .div_src1(div_src1), .div_src2(div_src2),
    .result_valid(result_valid), .result_ready(result_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    div_valid = 1'b1;
    div_op    = op;
    div_src1  = a;
    div_src2  = b;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    // Operands are scrambled after accept; the unit must ignore them.
    div_src1  = 64'hDEAD_BEEF_0BAD_F00D;
    div_src2  = 64'h0000_0000_0000_0003;
    div_op    = OP_REMU;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input int exp_lat, input logic [63:0] exp_res,
                       input int hold);
    int edges;
    logic stable;
    issue(op, a, b);
    edges = 0;
    while (!result_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_lat"}, 64'(edges), 64'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (result !== exp_res || result_valid !== 1'b1 || div_ready !== 1'b0) stable = 1'b0;
      end
      check({tag, "_hold"}, 64'(stable), 64'd1);
    end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check({tag, "_ack"}, {62'd0, result_valid, div_ready}, 64'd1);
  endtask

  initial begin
    logic seen;
    #2;
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_ready", 64'(div_ready), 64'd1);
    check("rst_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    do_op("div_m7_2",  OP_DIV,  -64'sd7, 64'd2, 64, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op("rem_m7_2",  OP_REM,  -64'sd7, 64'd2, 64, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op("divu_dz",   OP_DIVU, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op("remu_dz",   OP_REMU, 64'd5, 64'd0, 1, 64'd5, 0);
    do_op("div_ovf",   OP_DIV,  64'h8000_0000_0000_0000, '1, 1, 64'h8000_0000_0000_0000, 0);
    do_op("rem_ovf",   OP_REM,  64'h8000_0000_0000_0000, '1, 1, 64'd0, 0);
    do_op("divw_ovf",  OP_DIVW, 64'h0000_0000_8000_0000, '1, 1, 64'hFFFF_FFFF_8000_0000, 0);
    do_op("divuw_sx",  OP_DIVUW, 64'h1234_5678_8000_0000, 64'd1, 32, 64'hFFFF_FFFF_8000_0000, 0);
    do_op("remuw_7_3", OP_REMUW, 64'd7, 64'd3, 32, 64'd1, 0);
    do_op("divw_m7_2", OP_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, 32, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op("remw_m7_2", OP_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 32, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op("remw_dz",   OP_REMW, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 1,
          64'hFFFF_FFFF_8000_0001, 0);
    do_op("divu_hold", OP_DIVU, 64'd1000, 64'd9, 64, 64'd111, 10);

    // flush at CALC cycle 20
    issue(OP_DIVU, 64'd100, 64'd7);
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_ready", 64'(div_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (result_valid) seen = 1'b1;
    end
    check("flush_quiet", 64'(seen), 64'd0);

    // A request coinciding with flush must not be accepted.
    @(negedge clk);
    flush     = 1'b1;
    div_valid = 1'b1;
    div_op    = OP_DIVU;
    div_src1  = 64'd100;
    div_src2  = 64'd7;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    div_valid = 1'b0;
    check("flush_noacc", 64'(div_ready), 64'd1);

    do_op("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64, 64'd14, 0);

    // Asynchronous reset mid-CALC
    issue(OP_DIVU, 64'd100, 64'd7);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_valid", 64'(result_valid), 64'd0);
    check("arst_ready", 64'(div_ready), 64'd1);
    check("arst_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    do_op("remu_100_7", OP_REMU, 64'd100, 64'd7, 64, 64'd2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
